// File: rtl/conv3x3_engine.sv
// 3x3 convolution engine: 3-stage multiply / sum / shift-clamp pipeline with frame position tracking.
// Optional macro CONV3X3_ABS_EN: take |shifted sum| before clamping (edge-magnitude mode).
module conv3x3_engine #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [71:0] win,
  input  logic [35:0] coef,
  input  logic [2:0]  shift,
  output logic        out_valid,
  output logic [7:0]  out_pixel,
  output logic [8:0]  out_col,
  output logic [5:0]  out_row,
  output logic        busy,
  output logic        frame_done
);
  localparam int STAGES = 3;
  localparam int TAPS   = 9;
  localparam logic [8:0] COL_MAX = 9'(IMG_W - 1);
  localparam logic [5:0] ROW_MAX = 6'(IMG_H - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [STAGES:1]            vld_pipe;
  logic [TAPS-1:0][12:0]      prod;
  logic [2:0]                 sh1, sh2;
  logic signed [16:0]         sum_c, sum2;
  logic signed [16:0]         shifted, mag;
  logic [7:0]                 pix_c;
  logic [8:0]                 col_nxt;
  logic [5:0]                 row_nxt;
  logic                       last_px;
  logic [1:0]                 state;

  always_ff @(posedge clk) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  // Stage 1: pixels zero-extended, coefficients sign-extended, product fits 13 bits.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int i = 0; i < TAPS; i++)
        prod[i] <= $signed({5'd0, win[8*i +: 8]}) * $signed({{9{coef[4*i+3]}}, coef[4*i +: 4]});
      sh1 <= shift;
    end
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < TAPS; i++)
      sum_c = sum_c + $signed({{4{prod[i][12]}}, prod[i]});
  end

  // Stage 2: 9 * |-2040| = 18360 stays well inside 17-bit signed.
  always_ff @(posedge clk) begin
    if (vld_pipe[1]) begin
      sum2 <= sum_c;
      sh2  <= sh1;
    end
  end

  always_comb begin
    shifted = sum2 >>> sh2;
`ifdef CONV3X3_ABS_EN
    mag = shifted[16] ? -shifted : shifted;
`else
    mag = shifted;
`endif
    if (mag[16])              pix_c = 8'd0;
    else if (mag > 17'sd255)  pix_c = 8'hFF;
    else                      pix_c = mag[7:0];
  end

  // Stage 3 plus output position; out_pixel forced to 0 on bubbles.
  assign last_px = (col_nxt == COL_MAX) && (row_nxt == ROW_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_pixel  <= 8'd0;
      out_col    <= 9'd0;
      out_row    <= 6'd0;
      col_nxt    <= 9'd0;
      row_nxt    <= 6'd0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= vld_pipe[2];
      out_pixel  <= vld_pipe[2] ? pix_c : 8'd0;
      frame_done <= vld_pipe[2] && last_px;
      if (vld_pipe[2]) begin
        out_col <= col_nxt;
        out_row <= row_nxt;
        if (col_nxt == COL_MAX) begin
          col_nxt <= 9'd0;
          row_nxt <= (row_nxt == ROW_MAX) ? 6'd0 : row_nxt + 6'd1;
        end else begin
          col_nxt <= col_nxt + 9'd1;
        end
      end
    end
  end

  // Anything in the pipeline while IDLE was accepted during DONE and belongs to the next frame.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else begin
      case (state)
        S_IDLE:  if (in_valid || (|vld_pipe)) state <= S_RUN;
        S_RUN:   if (frame_done) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN) || ((state == S_IDLE) && (|vld_pipe));
endmodule

// File: doc/conv3x3_engine.md
CONV3X3_ENGINE -- requirements
Module: conv3x3_engine

Interface
REQ-001 SHALL have parameter IMG_W, default 256: output pixels per row.
REQ-002 SHALL have parameter IMG_H, default 32: output rows per frame.
REQ-003 SHALL have port clk, input, 1: clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: window on win is valid this cycle; no backpressure.
REQ-006 SHALL have port win, input, 72: 3x3 window, unsigned 8-bit pixels; p1 at [7:0] through p9 at [71:64]; p1-p3 top row, p4-p6 middle row, p7-p9 bottom row.
REQ-007 SHALL have port coef, input, 36: nine signed 4-bit coefficients; k1 at [3:0] through k9 at [35:32].
REQ-008 SHALL have port shift, input, 3: normalisation right-shift amount, 0-7.
REQ-009 SHALL have port out_valid, output, 1: out_pixel valid.
REQ-010 SHALL have port out_pixel, output, 8: filtered pixel.
REQ-011 SHALL have port out_col, output, 9: column index of out_pixel.
REQ-012 SHALL have port out_row, output, 6: row index of out_pixel.
REQ-013 SHALL have port busy, output, 1: frame in progress.
REQ-014 SHALL have port frame_done, output, 1: one-cycle pulse on the last pixel of a frame.

Function
REQ-015 SHALL sample win, coef and shift together only when in_valid=1; shift travels down the pipeline with its window.
REQ-016 SHALL use stage 1 to register nine products pN*kN, each 13-bit signed, with pixels zero-extended.
REQ-017 SHALL use stage 2 to register the 9-term sum as 17-bit signed, with no overflow possible.
REQ-018 SHALL use stage 3 to arithmetic-right-shift the sum by shift (floor rounding), clamp it to 0..255, and register it to out_pixel.
REQ-019 SHALL assert out_valid exactly 3 cycles after the corresponding in_valid, accepting one window per cycle at full throughput; in_valid gaps propagate as bubbles.
REQ-020 SHALL drive out_pixel to 0 whenever out_valid=0.
REQ-021 SHALL advance out_col on each out_valid, wrapping from IMG_W-1 to 0 and then incrementing out_row.
REQ-022 SHALL wrap out_row from IMG_H-1 to 0 at end of frame.
REQ-023 SHALL show out_col/out_row for the current output pixel, holding them while out_valid=0.
REQ-024 SHALL implement FSM states IDLE, RUN and DONE.
REQ-025 SHALL transition IDLE->RUN on the first in_valid.
REQ-026 SHALL transition RUN->DONE on the out_valid with out_col=IMG_W-1 and out_row=IMG_H-1.
REQ-027 SHALL transition DONE->IDLE unconditionally after one cycle.
REQ-028 SHALL assert frame_done in the same cycle as the last out_valid of the frame.
REQ-029 SHALL assert busy in RUN, and also in IDLE while any pipeline stage holds a valid window.
REQ-030 SHALL accept an in_valid arriving during DONE as the first window of the next frame, processing back-to-back frames without loss.
REQ-031 SHALL apply a coef or shift change mid-frame from the next sampled window only.

Reset
REQ-032 SHALL, on rst_n=0 at a clock edge, clear all pipeline valid bits, discard in-flight windows, and return the FSM to IDLE.
REQ-033 SHALL, on reset, set out_valid=0, out_pixel=0, out_col=0, out_row=0, busy=0 and frame_done=0.
REQ-034 SHALL apply reset mid-frame identically, with the first in_valid after release starting a new frame at row 0, col 0.

Configuration
REQ-035 SHALL, with macro CONV3X3_ABS_EN defined, take the absolute value of the shifted sum before clamping to 0..255 (edge-magnitude mode).
REQ-036 SHALL, without CONV3X3_ABS_EN, clamp negative shifted sums to 0.

Verification
REQ-037 SHALL cover identity: k5=1, others 0, shift=0, p5=0x7F, one in_valid -> out_valid 3 cycles later with out_pixel=0x7F, col 0, row 0.
REQ-038 SHALL cover box filter: all k=1, shift=3, all pixels 200 -> out_pixel=225 (1800>>3).
REQ-039 SHALL cover saturation: all k=1, shift=0, all pixels 255 -> out_pixel=255 (sum 2295).
REQ-040 SHALL cover negative result: k5=-1, others 0, p5=10 -> out_pixel=0 without macro, 10 with CONV3X3_ABS_EN.
REQ-041 SHALL cover a full frame: 8192 consecutive in_valid -> frame_done coincident with the 8192nd out_valid at col 255/row 31, busy=0 one cycle later, and a next frame immediately following starts at col 0/row 0.
REQ-042 SHALL cover mid-frame reset: reset after 100 inputs with 3 windows in flight -> out_valid=0 the cycle after the reset edge, no stale outputs, counters at 0.
